// File: rtl/dbus_pkg.sv
// Shared data-bus definitions: default widths, abort read word and
// arbitration policy encodings.
package dbus_pkg;

  localparam int          DBUS_ADDR_W       = 30;
  localparam int          DBUS_DATA_W       = 32;
  localparam logic [31:0] DBUS_TIMEOUT_DATA = 32'hDEADBEEF;

  localparam int PRIORITY_RR    = 0;
  localparam int PRIORITY_FIXED = 1;

  // Width of an index able to hold 0..n-1, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter_core.sv
// Combinational owner selection: round-robin after last_idx, or lowest
// requesting index wins.
module rr_arbiter_core
  import dbus_pkg::*;
#(
  parameter int NUM_MASTERS   = 2,
  parameter int PRIORITY_MODE = PRIORITY_RR,
  localparam int IDX_W        = idx_width(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]       last_idx,
  output logic [NUM_MASTERS-1:0] gnt,
  output logic [IDX_W-1:0]       gnt_idx,
  output logic                   any_req
);

  int cand;

  always_comb begin
    gnt_idx = '0;
    any_req = 1'b0;
    cand    = 0;
    if (PRIORITY_MODE == PRIORITY_FIXED) begin
      for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
        if (req[i]) gnt_idx = IDX_W'(i);
      end
      any_req = |req;
    end else begin
      // Walk last+1, last+2, ... wrapping; the first requester found wins.
      for (int k = 1; k <= NUM_MASTERS; k++) begin
        cand = int'(last_idx) + k;
        if (cand >= NUM_MASTERS) cand = cand - NUM_MASTERS;
        if (!any_req && req[cand]) begin
          any_req = 1'b1;
          gnt_idx = IDX_W'(cand);
        end
      end
    end
    gnt = any_req ? (NUM_MASTERS'(1) << gnt_idx) : '0;
  end

endmodule

// File: rtl/dbus_multi_master_arbiter.sv
// N-master data-bus arbiter: registered grant held through slave wait
// states, with a stall watchdog that aborts and returns an error word.
module dbus_multi_master_arbiter
  import dbus_pkg::*;
#(
  parameter int                NUM_MASTERS    = 2,
  parameter int                ADDR_W         = DBUS_ADDR_W,
  parameter int                DATA_W         = DBUS_DATA_W,
  parameter int                PRIORITY_MODE  = PRIORITY_RR,
  parameter int                TIMEOUT_CYCLES = 256,
  parameter logic [DATA_W-1:0] TIMEOUT_DATA   = DATA_W'(DBUS_TIMEOUT_DATA)
) (
  input  logic                              i_Clk,
  input  logic                              i_nReset,
  input  logic [NUM_MASTERS*ADDR_W-1:0]     i_M_Address,
  input  logic [NUM_MASTERS*(DATA_W/8)-1:0] i_M_ByteEn,
  input  logic [NUM_MASTERS-1:0]            i_M_Read,
  input  logic [NUM_MASTERS-1:0]            i_M_Write,
  input  logic [NUM_MASTERS*DATA_W-1:0]     i_M_WriteData,
  output logic [NUM_MASTERS*DATA_W-1:0]     o_M_ReadData,
  output logic [NUM_MASTERS-1:0]            o_M_WaitRequest,
  output logic [ADDR_W-1:0]                 o_S_Address,
  output logic [DATA_W/8-1:0]               o_S_ByteEn,
  output logic                              o_S_Read,
  output logic                              o_S_Write,
  output logic [DATA_W-1:0]                 o_S_WriteData,
  input  logic [DATA_W-1:0]                 i_S_ReadData,
  input  logic                              i_S_WaitRequest,
  output logic [NUM_MASTERS-1:0]            o_Gnt,
  output logic                              o_TimeoutPulse,
  output logic                              o_TimeoutErr,
  input  logic                              i_ClrErr
);

  localparam int              BE_W    = DATA_W / 8;
  localparam int              IDX_W   = idx_width(NUM_MASTERS);
  localparam int              CNT_W   = idx_width(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  logic                   valid_q, valid_d;
  logic [IDX_W-1:0]       owner_q, owner_d;
  logic [IDX_W-1:0]       last_q, last_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
  logic                   err_q, err_d;

  logic [NUM_MASTERS-1:0] req;
  logic                   own_req;
  logic                   done;
  logic                   abort;
  logic                   rearb;
  logic [NUM_MASTERS-1:0] arb_gnt;
  logic [IDX_W-1:0]       arb_idx;
  logic                   arb_any;

  assign req     = i_M_Read | i_M_Write;
  assign own_req = valid_q & req[owner_q];
  assign done    = own_req & ~i_S_WaitRequest;
  assign abort   = (TIMEOUT_CYCLES != 0) & valid_q & (cnt_q == CNT_MAX);
  // Release covers an owner that dropped its strobes without completing.
  assign rearb   = ~valid_q | done | abort | (valid_q & ~req[owner_q]);

  rr_arbiter_core #(
    .NUM_MASTERS  (NUM_MASTERS),
    .PRIORITY_MODE(PRIORITY_MODE)
  ) u_arb (
    .req     (req),
    .last_idx(last_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .any_req (arb_any)
  );

  always_comb begin
    valid_d = valid_q;
    owner_d = owner_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    cnt_d   = '0;
    err_d   = err_q;
    if (rearb) begin
      valid_d = arb_any;
      gnt_d   = arb_gnt;
      if (arb_any) begin
        owner_d = arb_idx;
        last_d  = arb_idx;
      end
    end else if (TIMEOUT_CYCLES != 0) begin
      // Holding the grant implies the owner is stalled by the slave.
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (abort) begin
      err_d = 1'b1;
    end else if (i_ClrErr) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge i_Clk or negedge i_nReset) begin
    if (!i_nReset) begin
      valid_q <= 1'b0;
      owner_q <= '0;
      last_q  <= IDX_W'(NUM_MASTERS - 1);
      cnt_q   <= '0;
      gnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    o_S_Address   = '0;
    o_S_ByteEn    = '0;
    o_S_Read      = 1'b0;
    o_S_Write     = 1'b0;
    o_S_WriteData = '0;
    if (valid_q) begin
      o_S_Address   = i_M_Address[owner_q*ADDR_W +: ADDR_W];
      o_S_ByteEn    = i_M_ByteEn[owner_q*BE_W +: BE_W];
      o_S_Read      = i_M_Read[owner_q] & ~abort;
      o_S_Write     = i_M_Write[owner_q] & ~abort;
      o_S_WriteData = i_M_WriteData[owner_q*DATA_W +: DATA_W];
    end
  end

  for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_resp
    logic own_sel;
    assign own_sel = valid_q & (owner_q == IDX_W'(gi));
    assign o_M_WaitRequest[gi] = ~(own_sel & (abort | ~i_S_WaitRequest));
    assign o_M_ReadData[gi*DATA_W +: DATA_W] =
      own_sel ? (abort ? TIMEOUT_DATA : i_S_ReadData) : '0;
  end

  assign o_Gnt          = gnt_q;
  assign o_TimeoutPulse = abort;
  assign o_TimeoutErr   = err_q;

endmodule

// File: tb/tb_dbus_multi_master_arbiter.sv
// Randomised bench: a round-robin and a fixed-priority arbiter share one
// set of masters and one slave, each compared against a transaction model.
module tb_dbus_multi_master_arbiter;

  localparam int N  = 3;
  localparam int AW = 30;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam logic [DW-1:0] DEAD = 32'hDEADBEEF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic [N*AW-1:0] m_addr;
  logic [N*BW-1:0] m_be;
  logic [N-1:0]    m_rd;
  logic [N-1:0]    m_wr;
  logic [N*DW-1:0] m_wdata;
  logic [DW-1:0]   s_rdata;
  logic            s_wait;
  logic            clr_err;

  logic [N*DW-1:0] rdata_o  [2];
  logic [N-1:0]    wait_o   [2];
  logic [AW-1:0]   saddr_o  [2];
  logic [BW-1:0]   sbe_o    [2];
  logic            srd_o    [2];
  logic            swr_o    [2];
  logic [DW-1:0]   swdata_o [2];
  logic [N-1:0]    gnt_o    [2];
  logic            pulse_o  [2];
  logic            err_o    [2];

  dbus_multi_master_arbiter #(
    .NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW),
    .PRIORITY_MODE(0), .TIMEOUT_CYCLES(4), .TIMEOUT_DATA(DEAD)
  ) u_rr (
    .i_Clk(clk), .i_nReset(rst_n),
    .i_M_Address(m_addr), .i_M_ByteEn(m_be), .i_M_Read(m_rd),
    .i_M_Write(m_wr), .i_M_WriteData(m_wdata),
    .o_M_ReadData(rdata_o[0]), .o_M_WaitRequest(wait_o[0]),
    .o_S_Address(saddr_o[0]), .o_S_ByteEn(sbe_o[0]), .o_S_Read(srd_o[0]),
    .o_S_Write(swr_o[0]), .o_S_WriteData(swdata_o[0]),
    .i_S_ReadData(s_rdata), .i_S_WaitRequest(s_wait),
    .o_Gnt(gnt_o[0]), .o_TimeoutPulse(pulse_o[0]), .o_TimeoutErr(err_o[0]),
    .i_ClrErr(clr_err)
  );

  dbus_multi_master_arbiter #(
    .NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW),
    .PRIORITY_MODE(1), .TIMEOUT_CYCLES(6), .TIMEOUT_DATA(DEAD)
  ) u_fp (
    .i_Clk(clk), .i_nReset(rst_n),
    .i_M_Address(m_addr), .i_M_ByteEn(m_be), .i_M_Read(m_rd),
    .i_M_Write(m_wr), .i_M_WriteData(m_wdata),
    .o_M_ReadData(rdata_o[1]), .o_M_WaitRequest(wait_o[1]),
    .o_S_Address(saddr_o[1]), .o_S_ByteEn(sbe_o[1]), .o_S_Read(srd_o[1]),
    .o_S_Write(swr_o[1]), .o_S_WriteData(swdata_o[1]),
    .i_S_ReadData(s_rdata), .i_S_WaitRequest(s_wait),
    .o_Gnt(gnt_o[1]), .o_TimeoutPulse(pulse_o[1]), .o_TimeoutErr(err_o[1]),
    .i_ClrErr(clr_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [95:0] got,
                           input logic [95:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Model state per instance: bus owned, owner, last owner, stall count, error.
  int mv [2], mo [2], ml [2], mc [2], me [2];
  int nv [2], no [2], nl [2], nc [2], ne [2];
  int hold [N];

  function automatic bit fixed_of(input int k);
    return k == 1;
  endfunction

  function automatic int tmo_of(input int k);
    return (k == 0) ? 4 : 6;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mv[k] = 0; mo[k] = 0; ml[k] = N - 1; mc[k] = 0; me[k] = 0;
    end
  endtask

  task automatic eval_check(input int k);
    logic [N-1:0]    req;
    logic [N-1:0]    e_gnt;
    logic [N-1:0]    e_wait;
    logic [N*DW-1:0] e_rdata;
    logic [AW-1:0]   e_addr;
    logic [BW-1:0]   e_be;
    logic [DW-1:0]   e_wdata;
    logic            e_rd, e_wr;
    bit              abort, done, rearb;
    int              w, c;
    string           nm;
    nm      = (k == 0) ? "rr" : "fp";
    req     = m_rd | m_wr;
    abort   = (mv[k] != 0) && (mc[k] == tmo_of(k));
    done    = (mv[k] != 0) && req[mo[k]] && !s_wait;
    e_gnt   = '0;
    e_wait  = '1;
    e_rdata = '0;
    e_addr  = '0; e_be = '0; e_wdata = '0; e_rd = 1'b0; e_wr = 1'b0;
    if (mv[k] != 0) begin
      e_gnt[mo[k]] = 1'b1;
      if (abort || !s_wait) e_wait[mo[k]] = 1'b0;
      e_rdata[mo[k]*DW +: DW] = abort ? DEAD : s_rdata;
      e_addr  = m_addr[mo[k]*AW +: AW];
      e_be    = m_be[mo[k]*BW +: BW];
      e_wdata = m_wdata[mo[k]*DW +: DW];
      e_rd    = m_rd[mo[k]] && !abort;
      e_wr    = m_wr[mo[k]] && !abort;
    end
    check_val({nm, "_gnt"},    96'(gnt_o[k]),    96'(e_gnt));
    check_val({nm, "_wait"},   96'(wait_o[k]),   96'(e_wait));
    check_val({nm, "_rdata"},  96'(rdata_o[k]),  96'(e_rdata));
    check_val({nm, "_saddr"},  96'(saddr_o[k]),  96'(e_addr));
    check_val({nm, "_sbe"},    96'(sbe_o[k]),    96'(e_be));
    check_val({nm, "_srd"},    96'(srd_o[k]),    96'(e_rd));
    check_val({nm, "_swr"},    96'(swr_o[k]),    96'(e_wr));
    check_val({nm, "_swdata"}, 96'(swdata_o[k]), 96'(e_wdata));
    check_val({nm, "_pulse"},  96'(pulse_o[k]),  96'(abort));
    check_val({nm, "_err"},    96'(err_o[k]),    96'(me[k] != 0));
    if (rst_n && (done || abort))
      $display("txn %s m%0d %s addr=%h %s", nm, mo[k],
               m_rd[mo[k]] ? "rd" : "wr", e_addr, abort ? "abort" : "ok");

    rearb = (mv[k] == 0) || done || abort || !req[mo[k]];
    nv[k] = mv[k]; no[k] = mo[k]; nl[k] = ml[k]; nc[k] = 0;
    if (rearb) begin
      w = -1;
      if (fixed_of(k)) begin
        for (int i = N - 1; i >= 0; i--) if (req[i]) w = i;
      end else begin
        for (int j = 1; j <= N; j++) begin
          c = (ml[k] + j) % N;
          if (w < 0 && req[c]) w = c;
        end
      end
      nv[k] = (w >= 0) ? 1 : 0;
      if (w >= 0) begin
        no[k] = w;
        nl[k] = w;
      end
    end else begin
      nc[k] = mc[k] + 1;
    end
    ne[k] = abort ? 1 : (clr_err ? 0 : me[k]);
  endtask

  task automatic step();
    s_rdata = $urandom;
    @(negedge clk);
    for (int k = 0; k < 2; k++) eval_check(k);
    @(posedge clk);
    if (rst_n) begin
      for (int k = 0; k < 2; k++) begin
        mv[k] = nv[k]; mo[k] = no[k]; ml[k] = nl[k]; mc[k] = nc[k]; me[k] = ne[k];
      end
    end else begin
      model_reset();
    end
    #1;
  endtask

  task automatic set_m(input int i, input logic rd, input logic wr,
                       input logic [AW-1:0] a);
    m_rd[i] = rd;
    m_wr[i] = wr;
    m_addr[i*AW +: AW]  = a;
    m_be[i*BW +: BW]    = BW'($urandom);
    m_wdata[i*DW +: DW] = $urandom;
  endtask

  task automatic clear_all();
    for (int i = 0; i < N; i++) set_m(i, 1'b0, 1'b0, '0);
  endtask

  task automatic idle(input int n);
    clear_all();
    s_wait = 1'b0;
    repeat (n) step();
  endtask

  initial begin
    rst_n   = 1'b0;
    m_addr  = '0; m_be = '0; m_rd = '0; m_wr = '0; m_wdata = '0;
    s_rdata = '0; s_wait = 1'b0; clr_err = 1'b0;
    for (int i = 0; i < N; i++) hold[i] = 0;
    model_reset();
    repeat (2) step();
    rst_n = 1'b1;

    // Single master against a zero-wait slave.
    set_m(0, 1'b1, 1'b0, 30'h3FC00000);
    repeat (2) step();
    idle(3);

    // All masters requesting continuously.
    for (int i = 0; i < N; i++) set_m(i, 1'b1, 1'b0, AW'($urandom));
    repeat (9) step();
    idle(2);

    // M1 stalled by the slave while M0 queues behind it.
    set_m(1, 1'b0, 1'b1, AW'($urandom));
    s_wait = 1'b1;
    step();
    set_m(0, 1'b1, 1'b0, AW'($urandom));
    repeat (5) step();
    s_wait = 1'b0;
    step();
    set_m(1, 1'b0, 1'b0, '0);
    repeat (3) step();
    idle(2);

    // Slave stuck in wait: watchdog aborts, error stays until cleared.
    set_m(0, 1'b1, 1'b0, AW'($urandom));
    s_wait = 1'b1;
    repeat (10) step();
    idle(3);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    repeat (2) step();

    // M0 and M2 competing, then M0 backs off.
    set_m(0, 1'b1, 1'b0, AW'($urandom));
    set_m(2, 1'b1, 1'b0, AW'($urandom));
    repeat (6) step();
    set_m(0, 1'b0, 1'b0, '0);
    repeat (4) step();
    idle(2);

    // Random traffic with periodic slave stall bursts.
    for (int cyc = 0; cyc < 300; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (hold[i] == 0) begin
          int r;
          r = $urandom_range(0, 9);
          if (r < 4)      set_m(i, 1'b0, 1'b0, '0);
          else if (r < 7) set_m(i, 1'b1, 1'b0, AW'($urandom));
          else            set_m(i, 1'b0, 1'b1, AW'($urandom));
          hold[i] = $urandom_range(1, 6);
        end else begin
          hold[i]--;
        end
      end
      s_wait  = ($urandom_range(0, 9) < 3) || ((cyc % 60) >= 52);
      clr_err = ($urandom_range(0, 19) == 0);
      step();
    end
    clr_err = 1'b0;
    idle(2);

    // Reset asserted while M1 is stalled mid-write.
    set_m(1, 1'b0, 1'b1, AW'($urandom));
    s_wait = 1'b1;
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check_val("rst_async_gnt", 96'(gnt_o[k]), 96'(0));
      check_val("rst_async_swr", 96'(swr_o[k]), 96'(0));
    end
    model_reset();
    s_wait = 1'b0;
    set_m(0, 1'b1, 1'b0, AW'($urandom));
    step();
    rst_n = 1'b1;
    step();
    for (int k = 0; k < 2; k++)
      check_val("rst_first_gnt", 96'(gnt_o[k]), 96'(3'b001));
    repeat (4) step();
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dbus_multi_master_arbiter.md
Name: dbus_multi_master_arbiter

Overview:
Parametrised N-master arbiter for the data bus, the next step up from the current single-CPU grant register. It sits between up to NUM_MASTERS DBus masters (CPU0, future DMA and video fetch) and the shared decoded slave bus. It selects one owner by round-robin or fixed priority and holds the grant through slave wait states. A watchdog aborts transactions the slave stalls for too long and returns an error word.

Parameters:
NUM_MASTERS, 2, number of master ports (2..8)
ADDR_W, 30, word-address width
DATA_W, 32, data width; byte-enable width = DATA_W/8
PRIORITY_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins)
TIMEOUT_CYCLES, 256, consecutive slave-wait cycles before abort; 0 disables the watchdog
TIMEOUT_DATA, 32'hDEADBEEF, ReadData returned on an aborted transaction

Ports:
i_Clk  in  1  system clock
i_nReset  in  1  asynchronous active-low reset
i_M_Address  in  NUM_MASTERS*ADDR_W  per-master address, master i at slice i
i_M_ByteEn  in  NUM_MASTERS*DATA_W/8  per-master byte enables
i_M_Read  in  NUM_MASTERS  per-master read strobe
i_M_Write  in  NUM_MASTERS  per-master write strobe
i_M_WriteData  in  NUM_MASTERS*DATA_W  per-master write data
o_M_ReadData  out  NUM_MASTERS*DATA_W  per-master read data
o_M_WaitRequest  out  NUM_MASTERS  per-master wait request
o_S_Address  out  ADDR_W  slave-bus address
o_S_ByteEn  out  DATA_W/8  slave-bus byte enables
o_S_Read  out  1  slave-bus read strobe
o_S_Write  out  1  slave-bus write strobe
o_S_WriteData  out  DATA_W  slave-bus write data
i_S_ReadData  in  DATA_W  OR-combined slave read data
i_S_WaitRequest  in  1  OR-combined slave wait request
o_Gnt  out  NUM_MASTERS  one-hot registered grant
o_TimeoutPulse  out  1  one-cycle pulse on each abort
o_TimeoutErr  out  1  sticky abort flag
i_ClrErr  in  1  clears o_TimeoutErr

Behaviour:
- Clock and reset: one clock i_Clk; reset i_nReset is asynchronous, active-low.
- Reset values: r_Valid=0, owner=0, last-owner=NUM_MASTERS-1, wait counter=0, o_Gnt=0, o_TimeoutErr=0, o_TimeoutPulse=0.
  - While reset or idle: slave strobes=0, slave address, byte enables and write data=0, all o_M_WaitRequest=1, all o_M_ReadData=0.
- Request: req[i] = i_M_Read[i] | i_M_Write[i].
- Slave mux: when r_Valid, the owner's Address, ByteEn, Read, Write and WriteData drive the slave bus combinationally; otherwise all slave outputs are 0.
- Master response: o_M_WaitRequest[i] = ~(r_Valid & owner==i & ~i_S_WaitRequest), except in the abort cycle (below). o_M_ReadData[owner] = i_S_ReadData; all non-owners see 0.
- Done = r_Valid & req[owner] & ~i_S_WaitRequest.
- Grant update (registered). Re-arbitrate when any of these hold:
  - !r_Valid
  - Done
  - abort
  - r_Valid & !req[owner] (owner dropped its request; release)
  Otherwise hold the grant.
- Arbitration policy:
  - Round-robin: search from last-owner+1 upward, wrapping modulo NUM_MASTERS; the first requester wins.
  - Fixed priority: the lowest requesting index wins.
  - No requester: r_Valid=0.
  - The winner's index becomes last-owner.
- Latency: request in cycle 0 → grant at edge → slave strobed in cycle 1. With a zero-wait slave, the master sees WaitRequest=0 in cycle 1 (1 cycle of arbitration latency).
- Back-to-back: in the Done cycle, re-arbitration sees current requests, so a competing master gets the next cycle with no idle bubble. A sole requester is re-granted immediately.
- Simultaneous requests: resolved purely by policy. Losers keep WaitRequest=1 and must hold their signals stable.
- Watchdog (TIMEOUT_CYCLES>0):
  - The counter increments while r_Valid & req[owner] & i_S_WaitRequest. It clears on Done, grant change or release.
  - When count==TIMEOUT_CYCLES, that cycle is the abort cycle:
    - o_S_Read=o_S_Write=0
    - o_M_WaitRequest[owner]=0
    - o_M_ReadData[owner]=TIMEOUT_DATA
    - o_TimeoutPulse=1
    - o_TimeoutErr set at the edge, then re-arbitrate.
  - i_ClrErr clears o_TimeoutErr; if i_ClrErr coincides with an abort, set wins.
- Reset mid-transaction: grant dropped immediately (asynchronous); slave strobes fall without waiting for the slave.

Decomposition:
- Shared package dbus_pkg: ADDR_W/DATA_W defaults, TIMEOUT_DATA constant, PRIORITY_RR/PRIORITY_FIXED encodings.
- One sub-module, rr_arbiter_core: a request vector plus last-owner in, one-hot grant plus index out, parametrised by NUM_MASTERS and PRIORITY_MODE; purely combinational.
- Grant, counter and muxing stay in the top module.

Test Plan:
- Single master, zero-wait slave: M0 read addr 0x3FC00000 at cycle 0 → o_Gnt=01 at cycle 1, o_S_Read=1, M0 WaitRequest low at cycle 1 only, ReadData passed through.
- Round-robin, NUM_MASTERS=3: all three masters issue continuous requests → grant order 0,1,2,0,1,2 with no idle cycles between Done and the next strobe.
- Wait-state hold: M1 owns the bus, slave WaitRequest high 5 cycles, M0 requests meanwhile → grant stays on M1 for 6 cycles, then M0 is granted next.
- Timeout, TIMEOUT_CYCLES=4: slave WaitRequest stuck high → abort in cycle 5 of the grant; M0 gets 0xDEADBEEF with WaitRequest=0; o_TimeoutPulse for 1 cycle; o_TimeoutErr stays high until i_ClrErr.
- Fixed priority, PRIORITY_MODE=1: M0 and M2 requesting continuously → M0 always wins; M2 is granted only when M0 drops its request.
- Async reset mid-wait: i_nReset low while M1 is stalled → o_Gnt=0, o_S_Write=0 in the same cycle; after release, M0 requesting is granted first.
